// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM states, default timing, frame width and the checksum helper.
package dht11_pkg;

    localparam int FRAME_W = 40;
    localparam int US_W    = 15;

    localparam int DEF_CLK_PER_US   = 100;
    localparam int DEF_START_MIN_US = 18000;
    localparam int DEF_RESP_DLY_US  = 30;
    localparam int DEF_T_PRE_US     = 80;
    localparam int DEF_T_BITLO_US   = 50;
    localparam int DEF_T_BIT0_US    = 26;
    localparam int DEF_T_BIT1_US    = 70;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_WAIT_REL = 3'd2,
        ST_RESP_LO  = 3'd3,
        ST_RESP_HI  = 3'd4,
        ST_BIT_LO   = 3'd5,
        ST_BIT_HI   = 3'd6,
        ST_END_LO   = 3'd7
    } dht11_state_e;

    function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond time base: clock prescaler plus a saturating microsecond counter, both cleared by srst.
module dht11_us_tick
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            srst,
    output logic [US_W-1:0] us_cnt
);
    localparam int              PW      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_PER_US - 1);
    localparam logic [PW-1:0]   PRE_ONE = PW'(1);
    localparam logic [US_W-1:0] US_MAX  = {US_W{1'b1}};
    localparam logic [US_W-1:0] US_ONE  = US_W'(1);

    logic [PW-1:0]   pre_cnt_r;
    logic [US_W-1:0] us_cnt_r;
    logic            tick_s;

    assign tick_s = (pre_cnt_r == PRE_MAX);
    assign us_cnt = us_cnt_r;

    // prescaler wraps once per microsecond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PW{1'b0}};
        end else if (srst || tick_s) begin
            pre_cnt_r <= {PW{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

    // microsecond counter holds at full scale instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt_r <= {US_W{1'b0}};
        end else if (srst) begin
            us_cnt_r <= {US_W{1'b0}};
        end else if (tick_s && (us_cnt_r != US_MAX)) begin
            us_cnt_r <= us_cnt_r + US_ONE;
        end
    end

endmodule

// File: rtl/dht11_sensor_tx.sv
// DHT11 sensor-side transmitter: answers a host start pulse with preamble and 40-bit frame.
// Define DHT11_TX_CONFLICT_DET_EN to abort a frame when the bus is pulled low in a released phase.
module dht11_sensor_tx
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US   = DEF_CLK_PER_US,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int RESP_DLY_US  = DEF_RESP_DLY_US,
    parameter int T_PRE_US     = DEF_T_PRE_US,
    parameter int T_BITLO_US   = DEF_T_BITLO_US,
    parameter int T_BIT0_US    = DEF_T_BIT0_US,
    parameter int T_BIT1_US    = DEF_T_BIT1_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       dq_in,
    output logic       dq_oe,
    output logic       busy,
    output logic       frame_done,
    output logic       bus_err
);
    localparam logic [US_W-1:0] START_MIN_C = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] RESP_DLY_C  = US_W'(RESP_DLY_US);
    localparam logic [US_W-1:0] T_PRE_C     = US_W'(T_PRE_US);
    localparam logic [US_W-1:0] T_BITLO_C   = US_W'(T_BITLO_US);
    localparam logic [US_W-1:0] T_BIT0_C    = US_W'(T_BIT0_US);
    localparam logic [US_W-1:0] T_BIT1_C    = US_W'(T_BIT1_US);

    dht11_state_e         state_r;
    logic                 dq_meta_r, dq_sync_r;
    logic                 restart_r, low_seen_r;
    logic [FRAME_W-1:0]   frame_r;
    logic [5:0]           bit_idx_r;
    logic                 dq_oe_r, in_ready_r, busy_r, frame_done_r, bus_err_r;
    logic [US_W-1:0]      us_cnt_s, dur_s;
    logic                 phase_done_s, accept_s, conflict_s;

    assign in_ready   = in_ready_r;
    assign dq_oe      = dq_oe_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign bus_err    = bus_err_r;

    // restart_r is raised with every phase change; the timer is unreliable until it clears
    dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk    (clk),
        .rst_n  (rst),
        .srst   (restart_r),
        .us_cnt (us_cnt_s)
    );

    assign phase_done_s = !restart_r && (us_cnt_s >= dur_s);
    assign accept_s     = in_valid && in_ready_r;

`ifdef DHT11_TX_CONFLICT_DET_EN
    localparam logic [US_W-1:0] GUARD_C = US_W'(2);
    assign conflict_s = ((state_r == ST_RESP_HI) || (state_r == ST_BIT_HI)) && !restart_r
                        && !dq_sync_r && (us_cnt_s >= GUARD_C);
`else
    assign conflict_s = 1'b0;
`endif

    // two-flop synchronizer on the bus level; idles high through the pull-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_meta_r <= 1'b1;
            dq_sync_r <= 1'b1;
        end else begin
            dq_meta_r <= dq_in;
            dq_sync_r <= dq_meta_r;
        end
    end

    // length of the current timed phase in microseconds
    always_comb begin
        dur_s = {US_W{1'b0}};
        case (state_r)
            ST_WAIT_REL:          dur_s = RESP_DLY_C;
            ST_RESP_LO, ST_RESP_HI: dur_s = T_PRE_C;
            ST_BIT_LO, ST_END_LO: dur_s = T_BITLO_C;
            ST_BIT_HI:            dur_s = frame_r[bit_idx_r] ? T_BIT1_C : T_BIT0_C;
            default:              dur_s = {US_W{1'b0}};
        endcase
    end

    // protocol FSM with registered bus drive and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            restart_r    <= 1'b1;
            low_seen_r   <= 1'b0;
            frame_r      <= {FRAME_W{1'b0}};
            bit_idx_r    <= 6'd0;
            dq_oe_r      <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            bus_err_r    <= 1'b0;
        end else begin
            restart_r    <= 1'b0;
            frame_done_r <= 1'b0;
            bus_err_r    <= 1'b0;
            if (accept_s) begin
                frame_r <= {hum_int, hum_dec, temp_int, temp_dec,
                            dht11_checksum(hum_int, hum_dec, temp_int, temp_dec)};
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_ARMED;
                        restart_r  <= 1'b1;
                        low_seen_r <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    // timer is held cleared while the bus is high, so it measures the host low
                    if (dq_sync_r) begin
                        restart_r  <= 1'b1;
                        low_seen_r <= 1'b0;
                        if (low_seen_r && !restart_r && (us_cnt_s >= START_MIN_C)) begin
                            state_r    <= ST_WAIT_REL;
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b0;
                        end
                    end else begin
                        low_seen_r <= 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (phase_done_s) begin
                        state_r   <= ST_RESP_LO;
                        dq_oe_r   <= 1'b1;
                        restart_r <= 1'b1;
                    end
                end
                ST_RESP_LO: begin
                    if (phase_done_s) begin
                        state_r   <= ST_RESP_HI;
                        dq_oe_r   <= 1'b0;
                        restart_r <= 1'b1;
                    end
                end
                ST_RESP_HI, ST_BIT_HI: begin
                    if (conflict_s) begin
                        state_r    <= ST_ARMED;
                        dq_oe_r    <= 1'b0;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                        bus_err_r  <= 1'b1;
                        low_seen_r <= 1'b0;
                        restart_r  <= 1'b1;
                    end else if (phase_done_s) begin
                        dq_oe_r   <= 1'b1;
                        restart_r <= 1'b1;
                        if (state_r == ST_RESP_HI) begin
                            state_r   <= ST_BIT_LO;
                            bit_idx_r <= 6'd39;
                        end else if (bit_idx_r == 6'd0) begin
                            state_r <= ST_END_LO;
                        end else begin
                            state_r   <= ST_BIT_LO;
                            bit_idx_r <= bit_idx_r - 6'd1;
                        end
                    end
                end
                ST_BIT_LO: begin
                    if (phase_done_s) begin
                        state_r   <= ST_BIT_HI;
                        dq_oe_r   <= 1'b0;
                        restart_r <= 1'b1;
                    end
                end
                ST_END_LO: begin
                    if (phase_done_s) begin
                        state_r      <= ST_ARMED;
                        dq_oe_r      <= 1'b0;
                        busy_r       <= 1'b0;
                        in_ready_r   <= 1'b1;
                        frame_done_r <= 1'b1;
                        low_seen_r   <= 1'b0;
                        restart_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    dq_oe_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
